// File: rtl/svm_stream_feeder.sv
// Burst reader: streams len words from a 1-cycle-latency BRAM onto the SVM sdata/svalid/sready port.
// Optional macro SVM_FEEDER_LAST_EN adds an slast output marking the final beat of each burst.
//
// state  | meaning
// IDLE   | waiting for start; captures base_addr/len
// RUN    | issuing reads and streaming beats
// DONE   | one-cycle done pulse, then back to IDLE
module svm_stream_feeder #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [WIDTH-1:0]  sdata,
  output logic              svalid,
  input  logic              sready
`ifdef SVM_FEEDER_LAST_EN
  ,
  output logic              slast
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  accepted;
  logic              inflight;
  logic [WIDTH-1:0]  buf_q [2];
  logic [1:0]        cnt;
  logic              rd_ptr;
  logic              wr_ptr;

  logic       hs;
  logic       issue;
  logic       push;
  logic       pop_buf;
  logic       final_beat;
  logic [1:0] occ;

  // Returning read data is visible on the stream in the same cycle it arrives,
  // so the in-flight slot acts as the third view of the 2-entry buffer.
  always_comb begin
    occ        = cnt + 2'(inflight);
    svalid     = (cnt != 2'd0) || inflight;
    if (cnt != 2'd0)
      sdata = buf_q[rd_ptr];
    else if (inflight)
      sdata = mem_rdata;
    else
      sdata = '0;
    hs         = svalid && sready;
    issue      = (state == S_RUN) && (issued < len_r) && ((occ != 2'd2) || hs);
    mem_en     = issue;
    mem_addr   = issue ? (base_r + ADDR_W'(issued)) : '0;
    pop_buf    = hs && (cnt != 2'd0);
    push       = inflight && !(hs && (cnt == 2'd0));
    final_beat = hs && (accepted == len_r - LEN_W'(1));
  end

`ifdef SVM_FEEDER_LAST_EN
  assign slast = svalid && (accepted == len_r - LEN_W'(1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      base_r   <= '0;
      len_r    <= '0;
      issued   <= '0;
      accepted <= '0;
      inflight <= 1'b0;
      cnt      <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      inflight <= issue;
      cnt      <= cnt + 2'(push) - 2'(pop_buf);
      if (push)
        wr_ptr <= ~wr_ptr;
      if (pop_buf)
        rd_ptr <= ~rd_ptr;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_r   <= base_addr;
            len_r    <= len;
            issued   <= '0;
            accepted <= '0;
            busy     <= 1'b1;
            if (len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (issue)
            issued <= issued + LEN_W'(1);
          if (hs)
            accepted <= accepted + LEN_W'(1);
          if (final_beat) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      buf_q[wr_ptr] <= mem_rdata;
  end

endmodule

// File: tb/tb_svm_stream_feeder.sv
// Scoreboard bench for svm_stream_feeder: expected beats/addresses queued at start, monitor compares.
// Define SVM_FEEDER_LAST_EN for both files to also check slast.
module tb_svm_stream_feeder;
  localparam int WIDTH = 16, ADDR_W = 16, LEN_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              busy, done, mem_en, svalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_rdata = '0;
  logic [WIDTH-1:0]  sdata;
  logic              sready = 1'b0;
`ifdef SVM_FEEDER_LAST_EN
  logic              slast;
`endif

  svm_stream_feeder #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_en(mem_en),
    .mem_rdata(mem_rdata), .sdata(sdata), .svalid(svalid), .sready(sready)
`ifdef SVM_FEEDER_LAST_EN
    , .slast(slast)
`endif
  );

  always #5 clk = ~clk;

  // Source memory: word at address a holds a*3.
  always @(posedge clk) if (mem_en) mem_rdata <= mem_addr * 16'd3;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] data; bit last; } beat_t;
  beat_t       exp_q[$];
  logic [15:0] addr_q[$];
  int en_log[$], beat_log[$], done_log[$];
  int checks = 0, errors = 0;
  int mode = 0, ph = 0, k_start = 0;

  task automatic chk_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // sready generator: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random
  initial forever begin
    @(posedge clk); #2;
    case (mode)
      0: sready = 1'b1;
      1: begin sready = (ph == 0) || (ph == 3); ph = (ph + 1) % 4; end
      default: sready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor / scoreboard
  int s, outstanding = 0;
  bit stall_prev = 0;
  logic [15:0] prev_data;
  bit prev_last;
  beat_t e;
  always @(negedge clk) begin
    if (reset) begin
      stall_prev  = 0;
      outstanding = 0;
    end else begin
      s = cyc + 1;
      if (mem_en) begin
        en_log.push_back(s);
        outstanding++;
        if (addr_q.size() == 0) chk_eq("unexpected_read_addr", mem_addr, 16'hxxxx);
        else chk_eq("read_addr", mem_addr, addr_q.pop_front());
      end
      if (!svalid) chk_eq("sdata_zero_when_idle", sdata, 0);
`ifdef SVM_FEEDER_LAST_EN
      if (!svalid) chk_eq("slast_low_when_idle", slast, 0);
`endif
      if (stall_prev) begin
        chk_eq("stall_svalid_held", svalid, 1);
        chk_eq("stall_sdata_held", sdata, prev_data);
`ifdef SVM_FEEDER_LAST_EN
        chk_eq("stall_slast_held", slast, prev_last);
`endif
      end
      if (svalid && sready) begin
        beat_log.push_back(s);
        outstanding--;
        if (exp_q.size() == 0) chk_eq("unexpected_beat", sdata, 16'hxxxx);
        else begin
          e = exp_q.pop_front();
          chk_eq("beat_data", sdata, e.data);
`ifdef SVM_FEEDER_LAST_EN
          chk_eq("beat_slast", slast, e.last);
`endif
        end
      end
      chk_eq("occupancy_le_2", int'(outstanding <= 2 && outstanding >= 0), 1);
      if (done) begin
        done_log.push_back(s);
        chk_eq("done_with_busy", busy, 1);
        chk_eq("done_all_beats_out", exp_q.size(), 0);
      end
      stall_prev = svalid && !sready;
      prev_data  = sdata;
`ifdef SVM_FEEDER_LAST_EN
      prev_last  = slast;
`else
      prev_last  = 1'b0;
`endif
    end
  end

  task automatic clear_logs();
    en_log.delete(); beat_log.delete(); done_log.delete();
  endtask

  // Reference model: a burst is the address list base+i (mod 2^16) read in order.
  task automatic do_start(input logic [15:0] b, input logic [15:0] l);
    beat_t t;
    logic [15:0] a;
    for (int i = 0; i < int'(l); i++) begin
      a = b + 16'(i);
      t.data = a * 16'd3;
      t.last = (i == int'(l) - 1);
      exp_q.push_back(t);
      addr_q.push_back(a);
    end
    base_addr = b; len = l; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    k_start = cyc;
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int i = 0; i < budget && done_log.size() == 0; i++) begin
      @(posedge clk); #2;
    end
    chk_eq(name, int'(done_log.size() > 0), 1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_svalid", svalid, 0);
    chk_eq("rst_sdata", sdata, 0);
    chk_eq("rst_mem_en", mem_en, 0);
    chk_eq("rst_mem_addr", mem_addr, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // Full-rate burst timing
    mode = 0;
    @(posedge clk); #2;
    clear_logs();
    do_start(16'h0010, 16'd4);
    wait_done(50, "full_done_seen");
    chk_eq("full_en_count", en_log.size(), 4);
    if (en_log.size() == 4) begin
      chk_eq("full_first_en", en_log[0], k_start + 1);
      chk_eq("full_last_en", en_log[3], k_start + 4);
    end
    chk_eq("full_beat_count", beat_log.size(), 4);
    if (beat_log.size() == 4) begin
      chk_eq("full_first_beat", beat_log[0], k_start + 2);
      chk_eq("full_last_beat", beat_log[3], k_start + 5);
    end
    chk_eq("full_done_count", done_log.size(), 1);
    if (done_log.size() == 1) chk_eq("full_done_cycle", done_log[0], k_start + 6);

    // Backpressure 1,0,0,1 over a long burst
    mode = 1;
    clear_logs();
    do_start(16'h0000, 16'd784);
    wait_done(4000, "bp_done_seen");
    chk_eq("bp_beat_count", beat_log.size(), 784);
    chk_eq("bp_done_count", done_log.size(), 1);
    chk_eq("bp_queue_empty", exp_q.size(), 0);

    // Zero length
    mode = 0;
    clear_logs();
    do_start(16'h0040, 16'd0);
    @(negedge clk);
    chk_eq("zero_busy_k1", busy, 1);
    chk_eq("zero_done_k1", done, 1);
    @(negedge clk);
    chk_eq("zero_busy_k2", busy, 0);
    chk_eq("zero_done_k2", done, 0);
    repeat (4) @(posedge clk);
    #2;
    chk_eq("zero_no_reads", en_log.size(), 0);
    chk_eq("zero_no_beats", beat_log.size(), 0);
    chk_eq("zero_done_count", done_log.size(), 1);

    // Start ignored mid-burst
    clear_logs();
    do_start(16'h0000, 16'd8);
    repeat (2) @(posedge clk);
    #2;
    base_addr = 16'h0100; len = 16'd5; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(60, "ign_done_seen");
    repeat (6) @(posedge clk);
    #2;
    chk_eq("ign_read_count", en_log.size(), 8);
    chk_eq("ign_beat_count", beat_log.size(), 8);
    chk_eq("ign_done_count", done_log.size(), 1);

    // Reset mid-burst
    mode = 1;
    clear_logs();
    do_start(16'h0300, 16'd10);
    for (int i = 0; i < 200 && beat_log.size() < 3; i++) begin
      @(posedge clk); #2;
    end
    chk_eq("rstmid_three_beats", int'(beat_log.size() >= 3), 1);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    exp_q.delete(); addr_q.delete(); clear_logs();
    @(negedge clk);
    chk_eq("rstmid_svalid", svalid, 0);
    chk_eq("rstmid_busy", busy, 0);
    chk_eq("rstmid_mem_en", mem_en, 0);
    @(posedge clk); #2;
    clear_logs();
    do_start(16'h0500, 16'd2);
    wait_done(40, "rstmid_done_seen");
    chk_eq("rstmid_beat_count", beat_log.size(), 2);
    chk_eq("rstmid_queue_empty", exp_q.size(), 0);

    // Single-beat burst
    mode = 2;
    clear_logs();
    do_start(16'h0700, 16'd1);
    wait_done(60, "one_done_seen");
    chk_eq("one_beat_count", beat_log.size(), 1);

    // Random bursts under random backpressure
    for (int n = 0; n < 6; n++) begin
      int l;
      l = $urandom_range(1, 40);
      clear_logs();
      do_start(16'($urandom), 16'(l));
      wait_done(l * 20 + 60, "rand_done_seen");
      chk_eq("rand_beat_count", beat_log.size(), l);
      chk_eq("rand_done_count", done_log.size(), 1);
    end

    // Address wrap (and slast on third beat when enabled)
    mode = 1;
    clear_logs();
    do_start(16'hFFFE, 16'd3);
    wait_done(60, "wrap_done_seen");
    chk_eq("wrap_beat_count", beat_log.size(), 3);
    chk_eq("wrap_queue_empty", exp_q.size(), 0);
    chk_eq("final_addr_queue_empty", addr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
